// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 block-mode sequencer: FSM encoding and widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm4_pkg;

    localparam int unsigned BLK_W = 128;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/sm4_mode_ctrl.sv
// SM4 block-mode sequencer: issues host blocks to sm4_core, applies CBC chaining
// (macro SM4_CBC_MODE_EN; ECB when undefined). Latency: accept T, core issue T+1, result T+2+L.
// Backpressure: o_ready low while a block is in flight or the key is not ready; i_din_en is dropped then.
module sm4_mode_ctrl
    import sm4_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flag,
    input  logic [BLK_W-1:0] i_iv,
    input  logic             i_iv_en,
    input  logic [BLK_W-1:0] i_din,
    input  logic             i_din_en,
    output logic             o_ready,
    output logic [BLK_W-1:0] o_dout,
    output logic             o_dout_en,
    output logic             o_err,
    output logic             o_core_flag,
    output logic [BLK_W-1:0] o_core_din,
    output logic             o_core_din_en,
    input  logic [BLK_W-1:0] i_core_dout,
    input  logic             i_core_dout_en,
    input  logic             i_core_key_ok
);

    // Last WAIT count before the response is declared lost.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_e           state_q, state_d;
    logic             flag_q, flag_d;
    logic [BLK_W-1:0] core_din_q, core_din_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic             dout_en_q, dout_en_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             rsp;
    logic             tmo;

`ifdef SM4_CBC_MODE_EN
    logic [BLK_W-1:0] chain_q, chain_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] chain_use;
`else
    // IV ports have no function in ECB builds.
    logic unused_iv;
    assign unused_iv = ^{i_iv, i_iv_en};
`endif

    assign o_ready = (state_q == IDLE) & i_core_key_ok;
    assign accept  = i_din_en & o_ready;
    // Responses outside WAIT are strays and never reach the datapath.
    assign rsp     = (state_q == WAIT) & i_core_dout_en;
    // A response on the final count beats the timeout.
    assign tmo     = (state_q == WAIT) & ~i_core_dout_en & (cnt_q == TMO_LAST);

    // Sequencer next state: one block in flight at a time.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (rsp || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response watchdog: cleared while issuing, counts every WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SEND) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath: capture on accept, chain and present on response.
    always_comb begin
        flag_d     = flag_q;
        core_din_d = core_din_q;
        dout_d     = dout_q;
        dout_en_d  = 1'b0;
        err_d      = tmo;
`ifdef SM4_CBC_MODE_EN
        blk_d      = blk_q;
        chain_d    = chain_q;
        chain_use  = chain_q;
        // An IV loaded alongside an accept must already apply to that block.
        if ((state_q == IDLE) && i_iv_en) begin
            chain_use = i_iv;
            chain_d   = i_iv;
        end
`endif
        if (accept) begin
            flag_d = i_flag;
`ifdef SM4_CBC_MODE_EN
            blk_d      = i_din;
            core_din_d = i_flag ? (i_din ^ chain_use) : i_din;
`else
            core_din_d = i_din;
`endif
        end
        if (rsp) begin
            dout_en_d = 1'b1;
`ifdef SM4_CBC_MODE_EN
            if (flag_q) begin
                dout_d  = i_core_dout;
                chain_d = i_core_dout;
            end else begin
                dout_d  = i_core_dout ^ chain_q;
                chain_d = blk_q;
            end
`else
            dout_d = i_core_dout;
`endif
        end
    end

    // State and datapath registers; reset aborts any block in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            core_din_q <= '0;
            dout_q     <= '0;
            dout_en_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef SM4_CBC_MODE_EN
            chain_q    <= '0;
            blk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            flag_q     <= flag_d;
            core_din_q <= core_din_d;
            dout_q     <= dout_d;
            dout_en_q  <= dout_en_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef SM4_CBC_MODE_EN
            chain_q    <= chain_d;
            blk_q      <= blk_d;
`endif
        end
    end

    assign o_dout        = dout_q;
    assign o_dout_en     = dout_en_q;
    assign o_err         = err_q;
    assign o_core_flag   = flag_q;
    assign o_core_din    = core_din_q;
    assign o_core_din_en = (state_q == SEND);

endmodule
